spk_in: RTL



---
 rtl/spk_pkg.sv | 31 +++
 rtl/spk_in_if.sv | 44 ++++
 rtl/data_fifo.sv | 51 +++++
 rtl/spk_in.sv | 126 ++++++++++++
 4 files changed

// File: rtl/spk_pkg.sv
// Shared constants for the spike/config flit receiver: field geometry,
// flit type codes and the dispatcher FSM encoding.
package spk_pkg;

  localparam int B        = 4;   // FIFO address width, depth 2^B
  localparam int FW       = 59;  // flit width
  localparam int FTW      = 3;   // flit type width
  localparam int SW       = 24;  // spike neuron-id width
  localparam int PW       = 36;  // payload width (below the router field)
  localparam int CW       = 8;   // DATA beat counter width
  localparam int TYPE_LSB = FW - FTW;  // type occupies [FW-1:TYPE_LSB]

  localparam logic [FTW-1:0] SPIKE    = 3'b000;
  localparam logic [FTW-1:0] DATA     = 3'b001;
  localparam logic [FTW-1:0] DATA_END = 3'b010;
  localparam logic [FTW-1:0] WRITE    = 3'b110;
  localparam logic [FTW-1:0] READ     = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SPK  = 2'd2,
    S_CFG  = 2'd3
  } state_t;

  // True for the four types that are routed to the config block.
  function automatic logic is_cfg_type(input logic [FTW-1:0] t);
    return (t == DATA) || (t == DATA_END) || (t == WRITE) || (t == READ);
  endfunction

endpackage

// File: rtl/spk_in_if.sv
// Signal bundle between the NI / node core and the flit receiver.
//
// Handshake: spk_in_valid/cfg_in_valid rise only with a complete, stable
// event; that event (and valid) is held unchanged until a cycle in which the
// matching ready is high, and the transfer happens on that rising clock edge.
// flit_in_wr is a pure strobe (no ready): upstream is throttled only by
// credit_out pulses.
interface spk_in_if;
  import spk_pkg::*;

  logic                     flit_in_wr;
  logic [FW-1:0]            flit_in;
  logic                     credit_out;
  logic                     spk_in_valid;
  logic [SW-1:0]            spk_in_neuid;
  logic                     spk_in_ready;
  logic                     cfg_in_valid;
  logic [FTW-1:0]           cfg_in_type;
  logic [PW-1:0]            cfg_in_data;
  logic                     cfg_in_last;
  logic [CW-1:0]            cfg_in_beat;
  logic                     cfg_in_ready;
  logic                     err_type;
  logic                     err_ovf;
  // Observation points: FSM state, FIFO level flags, router field of FIFO head.
  state_t                   dbg_state;
  logic                     dbg_fifo_empty;
  logic                     dbg_fifo_afull;
  logic [TYPE_LSB-PW-1:0]   dbg_route;

  modport slave (
    input  flit_in_wr, flit_in, spk_in_ready, cfg_in_ready,
    output credit_out, spk_in_valid, spk_in_neuid, cfg_in_valid, cfg_in_type,
           cfg_in_data, cfg_in_last, cfg_in_beat, err_type, err_ovf,
           dbg_state, dbg_fifo_empty, dbg_fifo_afull, dbg_route
  );

  modport master (
    output flit_in_wr, flit_in, spk_in_ready, cfg_in_ready,
    input  credit_out, spk_in_valid, spk_in_neuid, cfg_in_valid, cfg_in_type,
           cfg_in_data, cfg_in_last, cfg_in_beat, err_type, err_ovf,
           dbg_state, dbg_fifo_empty, dbg_fifo_afull, dbg_route
  );
endinterface

// File: rtl/data_fifo.sv
// Synchronous FIFO with registered read data (valid the cycle after rd_en).
// A push while full is accepted only when a pop happens in the same cycle;
// the pop frees the slot first.
module data_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr, count;
  logic                  do_wr, do_rd;

  assign count       = wr_ptr - rd_ptr;
  assign empty       = (count == '0);
  assign full        = (count == DEPTH_W);
  assign almost_full = (count == DEPTH_W - 1'b1);
  assign do_rd       = rd_en && !empty;
  assign do_wr       = wr_en && (!full || do_rd);

  // Storage array; no reset needed, occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[ADDR_WIDTH-1:0]] <= din;
  end

  // Pointer advance and registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
    end
  end
endmodule

// File: rtl/spk_in.sv
// Receive-side flit dispatcher: buffers credited flits, returns one credit per
// pop, and routes SPIKE flits to the neuron stage and config flits (with DATA
// burst beat tracking) to the config block. Bad types and overflow only raise
// sticky flags.
module spk_in
  import spk_pkg::*;
(
  input  logic     clk_spk_in,
  input  logic     rst_n,
  spk_in_if.slave  bus
);
  state_t          state_q, state_d;
  logic            pop;
  logic [FW-1:0]   fifo_dout;
  logic            fifo_full, fifo_afull, fifo_empty;
  logic [FTW-1:0]  head_type;
  logic            head_spike, head_cfg;

  logic            credit_q;
  logic [SW-1:0]   neuid_q;
  logic [FTW-1:0]  type_q;
  logic [PW-1:0]   data_q;
  logic            last_q;
  logic [CW-1:0]   beat_q;
  logic [CW-1:0]   beat_cnt_q;
  logic            err_type_q, err_ovf_q;

  data_fifo #(
    .DATA_WIDTH (FW),
    .ADDR_WIDTH (B)
  ) spk_in_fifo (
    .clk         (clk_spk_in),
    .rst_n       (rst_n),
    .wr_en       (bus.flit_in_wr),
    .din         (bus.flit_in),
    .rd_en       (pop),
    .dout        (fifo_dout),
    .full        (fifo_full),
    .almost_full (fifo_afull),
    .empty       (fifo_empty)
  );

  assign head_type  = fifo_dout[FW-1:TYPE_LSB];
  assign head_spike = (head_type == SPIKE);
  assign head_cfg   = is_cfg_type(head_type);

  // FSM state register.
  always_ff @(posedge clk_spk_in or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and pop decision; S_LOAD exists because FIFO read data lags the pop.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (head_spike)    state_d = S_SPK;
        else if (head_cfg) state_d = S_CFG;
        else               state_d = S_IDLE;
      end
      S_SPK:   if (bus.spk_in_ready) state_d = S_IDLE;
      S_CFG:   if (bus.cfg_in_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Event capture, beat counting, credit return and sticky error flags.
  always_ff @(posedge clk_spk_in or negedge rst_n) begin
    if (!rst_n) begin
      credit_q   <= 1'b0;
      neuid_q    <= '0;
      type_q     <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      beat_q     <= '0;
      beat_cnt_q <= '0;
      err_type_q <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      credit_q <= pop;
      if (state_q == S_LOAD) begin
        if (head_spike) begin
          neuid_q <= fifo_dout[SW-1:0];
        end else if (head_cfg) begin
          type_q <= head_type;
          data_q <= fifo_dout[PW-1:0];
          last_q <= (head_type == DATA_END);
          beat_q <= beat_cnt_q;
        end else begin
          err_type_q <= 1'b1;
        end
      end
      if ((state_q == S_CFG) && bus.cfg_in_ready) begin
        if (type_q == DATA) begin
          if (beat_cnt_q != {CW{1'b1}}) beat_cnt_q <= beat_cnt_q + 1'b1;
        end else begin
          beat_cnt_q <= '0;
        end
      end
      if (bus.flit_in_wr && fifo_full && !pop) err_ovf_q <= 1'b1;
    end
  end

  assign bus.credit_out     = credit_q;
  assign bus.spk_in_valid   = (state_q == S_SPK);
  assign bus.spk_in_neuid   = neuid_q;
  assign bus.cfg_in_valid   = (state_q == S_CFG);
  assign bus.cfg_in_type    = type_q;
  assign bus.cfg_in_data    = data_q;
  assign bus.cfg_in_last    = last_q;
  assign bus.cfg_in_beat    = beat_q;
  assign bus.err_type       = err_type_q;
  assign bus.err_ovf        = err_ovf_q;
  assign bus.dbg_state      = state_q;
  assign bus.dbg_fifo_empty = fifo_empty;
  assign bus.dbg_fifo_afull = fifo_afull;
  assign bus.dbg_route      = fifo_dout[TYPE_LSB-1:PW];
endmodule
